sdram_vga_reader: RTL and testbench

//  Display-side consumer of the SDRAM controller read FIFO (RD1 port). Generates
//  VGA raster timing and pulls one word per active pixel via RD1. Pulses RD1_LOAD
//  in vertical sync to clear the FIFO and rewind the read address each frame.

---
 rtl/sdram_vga_reader_if.sv | 12 +
 rtl/sdram_vga_reader.sv | 106 ++++++++++
 tb/tb_sdram_vga_reader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_vga_reader_if.sv
// Read-side bus between the SDRAM controller's RD1 FIFO and its display consumer.
// The master is the consumer: it drives rdreq and the load/rewind strobe and receives q.
interface sdram_vga_reader_if #(
  parameter int DSIZE = 16
);
  logic [DSIZE-1:0] RD1_DATA;
  logic             RD1;
  logic             RD1_LOAD;

  modport master (input RD1_DATA, output RD1, output RD1_LOAD);
  modport slave  (output RD1_DATA, input RD1, input RD1_LOAD);
endinterface

// File: rtl/sdram_vga_reader.sv
// VGA raster generator that streams one RD1 FIFO word per active pixel and
// rewinds the controller read pointer during vertical sync of each enabled frame.
module sdram_vga_reader #(
  parameter int DSIZE    = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LOAD_CYC = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  sdram_vga_reader_if.master   rd1,
  output logic                 VGA_HS_N,
  output logic                 VGA_VS_N,
  output logic                 VGA_DE,
  output logic [DSIZE-1:0]     PIX_DATA,
  output logic                 FRAME_ST
);

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [7:0]  LOAD_M1 = 8'(LOAD_CYC - 1);

  logic [11:0] h_cnt_reg;
  logic [11:0] v_cnt_reg;
  logic        frame_en_reg;
  logic [7:0]  load_cnt_reg;
  logic [1:0]  de_dly_reg;
  logic [1:0]  hs_dly_reg;
  logic [1:0]  vs_dly_reg;
  logic [1:0]  st_dly_reg;

  logic act;
  logic hs;
  logic vs;
  logic vs_start;
  logic first_pix;

  assign act       = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs        = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
  assign vs        = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
  assign vs_start  = (h_cnt_reg == 12'd0) && (v_cnt_reg == VS_BEG);
  assign first_pix = (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_cnt_reg    <= '0;
      v_cnt_reg    <= '0;
      frame_en_reg <= 1'b0;
      load_cnt_reg <= '0;
      de_dly_reg   <= '0;
      hs_dly_reg   <= '0;
      vs_dly_reg   <= '0;
      st_dly_reg   <= '0;
      rd1.RD1      <= 1'b0;
      rd1.RD1_LOAD <= 1'b1;
      VGA_HS_N     <= 1'b1;
      VGA_VS_N     <= 1'b1;
      VGA_DE       <= 1'b0;
      PIX_DATA     <= '0;
      FRAME_ST     <= 1'b0;
    end else begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_reg <= '0;
        v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 12'd1;
      end

      // The frame decision is taken once in vsync, so the frame being read always completes.
      if (vs_start) begin
        frame_en_reg <= ENABLE;
        load_cnt_reg <= ENABLE ? LOAD_M1 : 8'd0;
      end else if (load_cnt_reg != 8'd0) begin
        load_cnt_reg <= load_cnt_reg - 8'd1;
      end
      rd1.RD1_LOAD <= vs_start || !frame_en_reg || (load_cnt_reg != 8'd0);

      // Stage 1 issues rdreq; q arrives at stage 2 and is registered to the pins at stage 3.
      rd1.RD1    <= act && frame_en_reg;
      de_dly_reg <= {de_dly_reg[0], act && frame_en_reg};
      hs_dly_reg <= {hs_dly_reg[0], hs};
      vs_dly_reg <= {vs_dly_reg[0], vs};
      st_dly_reg <= {st_dly_reg[0], first_pix && frame_en_reg};

      VGA_DE   <= de_dly_reg[1];
      VGA_HS_N <= !hs_dly_reg[1];
      VGA_VS_N <= !vs_dly_reg[1];
      FRAME_ST <= st_dly_reg[1];
      PIX_DATA <= de_dly_reg[1] ? rd1.RD1_DATA : '0;
    end
  end

endmodule

// File: tb/tb_sdram_vga_reader.sv
// Bench for sdram_vga_reader on a reduced raster, with a normal-mode FIFO model
// feeding sequential words and a queue of expected pixels.
module tb_sdram_vga_reader;

  localparam int H_A = 8, H_FP = 2, H_S = 3, H_B = 3;
  localparam int V_A = 4, V_FP = 1, V_S = 2, V_B = 2;
  localparam int LOAD = 4;
  localparam int H_T = H_A + H_FP + H_S + H_B;
  localparam int V_T = V_A + V_FP + V_S + V_B;
  localparam int F   = H_T * V_T;
  localparam int VS0 = (V_A + V_FP) * H_T;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        VGA_HS_N, VGA_VS_N, VGA_DE, FRAME_ST;
  logic [15:0] PIX_DATA;
  logic [15:0] fifo_q = '0;
  int          fifo_addr = 0;
  int          cyc = 0;
  int          de_idx = 0;
  bit          acct_on = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_q[$];
  int          rd_cnt[8]   = '{default: 0};
  int          load_cnt[8] = '{default: 0};
  int          de_cnt[8]   = '{default: 0};
  int          hs_cnt[8]   = '{default: 0};
  int          vs_cnt[8]   = '{default: 0};
  int          fst_cnt[8]  = '{default: 0};

  sdram_vga_reader_if #(.DSIZE(16)) bus ();

  sdram_vga_reader #(
    .DSIZE(16), .H_ACTIVE(H_A), .H_FP(H_FP), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_FP), .V_SYNC(V_S), .V_BP(V_B), .LOAD_CYC(LOAD)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ENABLE   (ENABLE),
    .rd1      (bus.master),
    .VGA_HS_N (VGA_HS_N),
    .VGA_VS_N (VGA_VS_N),
    .VGA_DE   (VGA_DE),
    .PIX_DATA (PIX_DATA),
    .FRAME_ST (FRAME_ST)
  );

  always #5 CLK = ~CLK;

  assign bus.RD1_DATA = fifo_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    int n = 0;
    while (cyc != t && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_cyc", cyc, t);
  endtask

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Normal-mode FIFO: q follows rdreq by one clock; load clears and rewinds to word 0.
  always @(posedge CLK) begin
    if (!RESET_N) begin
      fifo_addr <= 0;
      fifo_q    <= '0;
      exp_q.delete();
    end else if (bus.RD1_LOAD) begin
      fifo_addr <= 0;
    end else if (bus.RD1) begin
      fifo_q    <= 16'(fifo_addr);
      fifo_addr <= fifo_addr + 1;
      exp_q.push_back(fifo_addr);
    end
  end

  always @(negedge CLK) begin
    if (RESET_N) begin
      automatic bit fs  = (cyc >= 3) && (((cyc - 3) % F) == 0);
      automatic int cur = fs ? 0 : de_idx;
      if (acct_on && cyc >= 1 && (cyc - 1) / F < 8) begin
        rd_cnt[(cyc - 1) / F]   <= rd_cnt[(cyc - 1) / F] + int'(bus.RD1);
        load_cnt[(cyc - 1) / F] <= load_cnt[(cyc - 1) / F] + int'(bus.RD1_LOAD);
      end
      if (acct_on && cyc >= 3 && (cyc - 3) / F < 8) begin
        de_cnt[(cyc - 3) / F]  <= de_cnt[(cyc - 3) / F] + int'(VGA_DE);
        hs_cnt[(cyc - 3) / F]  <= hs_cnt[(cyc - 3) / F] + int'(!VGA_HS_N);
        vs_cnt[(cyc - 3) / F]  <= vs_cnt[(cyc - 3) / F] + int'(!VGA_VS_N);
        fst_cnt[(cyc - 3) / F] <= fst_cnt[(cyc - 3) / F] + int'(FRAME_ST);
      end
      if (VGA_DE) begin
        if (exp_q.size() == 0) chk("q_empty", 1, 0);
        else                   chk("pix", PIX_DATA, exp_q.pop_front());
        chk("pix_idx", PIX_DATA, cur);
      end else begin
        chk("pix_idle", PIX_DATA, 0);
      end
      chk("fst", FRAME_ST, VGA_DE && cur == 0);
      de_idx <= cur + int'(VGA_DE);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    automatic bit en_f[6]  = '{0, 0, 0, 1, 1, 0};
    automatic bit smp_f[6] = '{0, 0, 1, 1, 0, 1};
    automatic int first_hs = -1;

    #20 RESET_N = 1'b1;
    acct_on = 1'b1;
    #2;
    chk("rst_rd1", bus.RD1, 0);
    chk("rst_load", bus.RD1_LOAD, 1);
    chk("rst_hs", VGA_HS_N, 1);
    chk("rst_vs", VGA_VS_N, 1);
    chk("rst_de", VGA_DE, 0);
    chk("rst_pix", PIX_DATA, 0);

    wait_cyc(2 * F + 20);
    ENABLE = 1'b1;
    wait_cyc(4 * F + 2 * H_T + 1);
    ENABLE = 1'b0;
    wait_cyc(5 * F + 40);
    ENABLE = 1'b1;
    wait_cyc(6 * F + 3);
    acct_on = 1'b0;

    for (int k = 0; k < 6; k++) begin
      $display("frame %0d: reads=%0d de=%0d hs=%0d vs=%0d load=%0d fst=%0d",
               k, rd_cnt[k], de_cnt[k], hs_cnt[k], vs_cnt[k], load_cnt[k], fst_cnt[k]);
      chk("frame_reads", rd_cnt[k], en_f[k] ? H_A * V_A : 0);
      chk("frame_de", de_cnt[k], en_f[k] ? H_A * V_A : 0);
      chk("frame_fst", fst_cnt[k], en_f[k] ? 1 : 0);
      chk("frame_hs", hs_cnt[k], V_T * H_S);
      chk("frame_vs", vs_cnt[k], V_S * H_T);
      chk("frame_load", load_cnt[k], (en_f[k] ? 0 : VS0) + (smp_f[k] ? LOAD : F - VS0));
    end

    wait_cyc(6 * F + 35);
    chk("pre_rst_de", VGA_DE, 1);
    chk("pre_rst_load", bus.RD1_LOAD, 0);
    #1 RESET_N = 1'b0;
    #1;
    chk("mid_rst_rd1", bus.RD1, 0);
    chk("mid_rst_load", bus.RD1_LOAD, 1);
    chk("mid_rst_hs", VGA_HS_N, 1);
    chk("mid_rst_vs", VGA_VS_N, 1);
    chk("mid_rst_de", VGA_DE, 0);
    chk("mid_rst_pix", PIX_DATA, 0);
    chk("mid_rst_fst", FRAME_ST, 0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4 * H_T; i++) begin
      @(negedge CLK);
      if (!VGA_HS_N) begin
        first_hs = cyc;
        break;
      end
    end
    $display("after reset: first HS_N low at clk %0d", first_hs);
    chk("hs_first", first_hs, H_A + H_FP + 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
